// File: rtl/rhs_spi_slave.sv
// SPI mode-0 slave running on the system clock: synchronizes SCLK/CS/MOSI,
// shifts one WORD_WIDTH frame per CS window and flags framing and underrun events.
module rhs_spi_slave #(
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  tx_underrun,
  output logic                  active
);
  localparam int CNT_W  = $clog2(WORD_WIDTH + 2);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_prev_r;
  logic [FILL_W-1:0]      fill_r;
  logic                   armed_r;
  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [WORD_WIDTH-1:0]  tx_shift_r;
  logic [WORD_WIDTH-1:0]  rx_shift_r;
  logic [WORD_WIDTH-1:0]  hold_r;
  logic                   pending_r;

  logic                   sclk_q_s;
  logic                   cs_q_s;
  logic                   mosi_q_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic [WORD_WIDTH-1:0]  start_word_s;

  assign sclk_q_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_q_s      = cs_sync_r[SYNC_STAGES-1];
  assign mosi_q_s    = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_q_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_q_s & sclk_prev_r;
  assign cs_fall_s   = armed_r & cs_prev_r & ~cs_q_s;
  assign cs_rise_s   = cs_q_s & ~cs_prev_r;
  // A tx_load coinciding with the frame start bypasses the holding register.
  assign start_word_s = tx_load   ? tx_data :
                        pending_r ? hold_r  : {WORD_WIDTH{1'b0}};

  // Input synchronizers plus one extra sample per line for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r[0] <= SCLK;
      cs_sync_r[0]   <= CS;
      mosi_sync_r[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_r[i] <= sclk_sync_r[i-1];
        cs_sync_r[i]   <= cs_sync_r[i-1];
        mosi_sync_r[i] <= mosi_sync_r[i-1];
      end
      sclk_prev_r <= sclk_q_s;
      cs_prev_r   <= cs_q_s;
    end
  end

  // Arm frame detection only once a real CS-high sample has left the synchronizer,
  // so a CS held low across reset cannot fake a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r  <= {FILL_W{1'b0}};
      armed_r <= 1'b0;
    end else begin
      if (fill_r != FILL_DONE) begin
        fill_r <= fill_r + FILL_ONE;
      end
      if ((fill_r == FILL_DONE) && cs_q_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Frame state machine with registered MISO, status pulses and tx holding logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      MISO        <= 1'b0;
      rx_data     <= {WORD_WIDTH{1'b0}};
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      active      <= 1'b0;
      hold_r      <= {WORD_WIDTH{1'b0}};
      pending_r   <= 1'b0;
      tx_shift_r  <= {WORD_WIDTH{1'b0}};
      rx_shift_r  <= {WORD_WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      case (state_r)
        IDLE: begin
          MISO <= 1'b0;
          if (cs_fall_s) begin
            state_r     <= SHIFT;
            active      <= 1'b1;
            bit_cnt_r   <= {CNT_W{1'b0}};
            tx_shift_r  <= start_word_s;
            MISO        <= start_word_s[WORD_WIDTH-1];
            tx_underrun <= ~tx_load & ~pending_r;
            pending_r   <= 1'b0;
          end else if (tx_load) begin
            hold_r    <= tx_data;
            pending_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (tx_load) begin
            hold_r    <= tx_data;
            pending_r <= 1'b1;
          end
          if (cs_rise_s) begin
            state_r <= IDLE;
            active  <= 1'b0;
            MISO    <= 1'b0;
            if (bit_cnt_r == CNT_FULL) begin
              rx_data  <= rx_shift_r;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise_s) begin
              rx_shift_r <= {rx_shift_r[WORD_WIDTH-2:0], mosi_q_s};
              if (bit_cnt_r != CNT_SAT) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end
            if (sclk_fall_s) begin
              tx_shift_r <= {tx_shift_r[WORD_WIDTH-2:0], 1'b0};
              MISO       <= tx_shift_r[WORD_WIDTH-2];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          active  <= 1'b0;
          MISO    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhs_spi_slave.sv
// Directed-plus-random bench for rhs_spi_slave acting as a mode-0 SPI master at clk/8,
// predicting MISO streams, rx words and status pulses from a word-level model.
module tb_rhs_spi_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [31:0] tx_data;
  logic        tx_load;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        tx_underrun;
  logic        active;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_under = 0;
  int n_both = 0;

  // Word-level reference state: holding word, pending flag, last good rx word.
  logic [31:0] hold_m;
  bit          pending_m;
  logic [31:0] rx_m;

  rhs_spi_slave #(.WORD_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .tx_underrun(tx_underrun), .active(active)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (frame_err) n_err++;
    if (tx_underrun) n_under++;
    if (rx_valid && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] d);
    tx_data = d;
    tx_load = 1'b1;
    clk_wait(1);
    tx_load = 1'b0;
    hold_m = d;
    pending_m = 1'b1;
  endtask

  // n SCLK pulses, MOSI MSB first, MISO captured at each rising edge.
  task automatic pulses(input logic [31:0] w, input int n, input bit mid,
                        input logic [31:0] mid_d, output logic [31:0] got);
    got = 32'h0;
    for (int i = 0; i < n; i++) begin
      MOSI = (i < 32) ? w[31-i] : 1'b0;
      if (mid && i == 16) begin
        tx_data = mid_d;
        tx_load = 1'b1;
        clk_wait(1);
        tx_load = 1'b0;
        clk_wait(3);
      end else begin
        clk_wait(4);
      end
      SCLK = 1'b1;
      got = {got[30:0], MISO};
      clk_wait(4);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
  endtask

  task automatic frame(input logic [31:0] w, input int n, input bit byp,
                       input logic [31:0] byp_d, input bit mid, input logic [31:0] mid_d);
    logic [31:0] exp_tx;
    logic [31:0] exp_got;
    logic [31:0] got;
    bit          exp_un;
    bit          good;
    int v0, e0, u0;
    v0 = n_valid; e0 = n_err; u0 = n_under;
    good = (n == 32);
    if (byp) begin
      exp_tx = byp_d; exp_un = 1'b0; pending_m = 1'b0;
    end else if (pending_m) begin
      exp_tx = hold_m; exp_un = 1'b0; pending_m = 1'b0;
    end else begin
      exp_tx = 32'h0; exp_un = 1'b1;
    end
    exp_got = 32'h0;
    for (int i = 0; i < n; i++) exp_got = {exp_got[30:0], (i < 32) ? exp_tx[31-i] : 1'b0};

    CS = 1'b0;
    clk_wait(2);
    if (byp) begin
      tx_data = byp_d;
      tx_load = 1'b1;
    end
    clk_wait(1);
    tx_load = 1'b0;
    clk_wait(5);
    check("active_in_frame", {31'h0, active}, 32'h1);
    pulses(w, n, mid, mid_d, got);
    if (mid) begin
      hold_m = mid_d; pending_m = 1'b1;
    end
    check("miso_stream", got, exp_got);
    clk_wait(8);
    CS = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("latency_early", {30'h0, rx_valid, frame_err}, 32'h0);
    @(posedge clk);
    #1;
    check("rx_valid", {31'h0, rx_valid}, {31'h0, good});
    check("frame_err", {31'h0, frame_err}, {31'h0, ~good});
    check("miso_idle", {31'h0, MISO}, 32'h0);
    check("active_off", {31'h0, active}, 32'h0);
    if (good) rx_m = w;
    check("rx_data", rx_data, rx_m);
    @(posedge clk);
    #1;
    check("pulse_width", {30'h0, rx_valid, frame_err}, 32'h0);
    check("underrun_cnt", n_under - u0, {31'h0, exp_un});
    check("valid_cnt", n_valid - v0, {31'h0, good});
    check("err_cnt", n_err - e0, {31'h0, ~good});
    clk_wait(6);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] got;
    int v0, e0, u0, nb;
    rst = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; tx_data = 32'h0; tx_load = 1'b0;
    hold_m = 32'h0; pending_m = 1'b0; rx_m = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_miso", {31'h0, MISO}, 32'h0);
    check("rst_rx_data", rx_data, 32'h0);
    check("rst_flags", {28'h0, rx_valid, frame_err, tx_underrun, active}, 32'h0);
    rst = 1'b0;
    clk_wait(10);

    // Basic frame with preloaded response word.
    load(32'hA5A5_0F0F);
    frame(32'h8123_4567, 32, 1'b0, 32'h0, 1'b0, 32'h0);
    // Short, long and empty frames: framing errors, rx_data retained.
    frame($urandom(), 31, 1'b0, 32'h0, 1'b0, 32'h0);
    frame($urandom(), 33, 1'b0, 32'h0, 1'b0, 32'h0);
    frame($urandom(), 0, 1'b0, 32'h0, 1'b0, 32'h0);
    // Underrun frame still delivers rx word.
    frame($urandom(), 32, 1'b0, 32'h0, 1'b0, 32'h0);
    // Bypass load at frame start.
    frame($urandom(), 32, 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    // Mid-frame load affects only the next frame.
    load(32'h0000_FFFF);
    frame($urandom(), 32, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    frame($urandom(), 32, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset mid-frame after 12 bits with CS held low.
    load($urandom());
    v0 = n_valid; e0 = n_err; u0 = n_under;
    CS = 1'b0;
    clk_wait(8);
    rnd = $urandom();
    pulses(rnd, 12, 1'b0, 32'h0, got);
    clk_wait(2);
    rst = 1'b1;
    #1;
    check("midrst_miso", {31'h0, MISO}, 32'h0);
    check("midrst_active", {31'h0, active}, 32'h0);
    check("midrst_rx_data", rx_data, 32'h0);
    hold_m = 32'h0; pending_m = 1'b0; rx_m = 32'h0;
    clk_wait(3);
    rst = 1'b0;
    clk_wait(20);
    check("cs_low_after_rst", {31'h0, active}, 32'h0);
    CS = 1'b1;
    clk_wait(10);
    check("midrst_pulses", (n_valid - v0) + (n_err - e0) + (n_under - u0), 32'h0);
    frame($urandom(), 32, 1'b0, 32'h0, 1'b0, 32'h0);

    // Randomized traffic against the word-level model.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) != 0) load($urandom());
      nb = 32;
      if ($urandom_range(0, 3) == 0) nb = ($urandom_range(0, 1) != 0) ? 31 : 33;
      if ($urandom_range(0, 4) == 0)
        frame($urandom(), nb, 1'b1, $urandom(), 1'b0, 32'h0);
      else
        frame($urandom(), nb, 1'b0, 32'h0, ($urandom_range(0, 2) == 0), $urandom());
    end

    check("valid_err_exclusive", n_both, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rhs_spi_slave.md
RHS_SPI_SLAVE -- requirements
Module: rhs_spi_slave

Interface
REQ-001 Parameter WORD_WIDTH, default 32, bits per SPI frame.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops on SCLK/CS/MOSI.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 SCLK  input  1  SPI clock from master, asynchronous to clk, idle low.
REQ-006 CS  input  1  chip select from master, active-low.
REQ-007 MOSI  input  1  serial data from master, MSB first.
REQ-008 MISO  output  1  serial data to master, MSB first.
REQ-009 tx_data  input  WORD_WIDTH  response word for the next frame.
REQ-010 tx_load  input  1  strobe; captures tx_data into holding register.
REQ-011 rx_data  output  WORD_WIDTH  last correctly framed received word.
REQ-012 rx_valid  output  1  one-clk pulse; rx_data updated.
REQ-013 frame_err  output  1  one-clk pulse; frame closed with wrong bit count.
REQ-014 tx_underrun  output  1  one-clk pulse; frame started with no new tx word pending.
REQ-015 active  output  1  high while a frame is in progress (state SHIFT).

Function
REQ-016 SCLK, CS, MOSI SHALL each pass through SYNC_STAGES flops before use; edges SHALL be detected from the last two synchronized samples.
REQ-017 Supported SCLK: high and low phases each >= 3 clk periods; CS setup/hold to first/last SCLK edge >= 3 clk periods.
REQ-018 States: IDLE, SHIFT; IDLE->SHIFT on synchronized CS falling edge; SHIFT->IDLE on synchronized CS rising edge.
REQ-019 On IDLE->SHIFT: bit counter cleared; tx shifter loaded from holding register; MISO driven with shifter MSB in the same clk.
REQ-020 If tx_load is asserted in the same clk as the CS falling edge, the incoming tx_data SHALL be loaded into the shifter (bypass) and pending cleared.
REQ-021 Pending flag set by tx_load, cleared when consumed at frame start; if clear at frame start, the shifter SHALL load all-zeros and tx_underrun SHALL pulse.
REQ-022 tx_load during SHIFT SHALL update holding register only; the word in flight is unaffected.
REQ-023 In SHIFT, on each synchronized SCLK rising edge: MOSI (synchronized sample) shifted into rx shifter LSB; bit counter incremented, saturating at WORD_WIDTH+1.
REQ-024 In SHIFT, on each synchronized SCLK falling edge: tx shifter shifted left by one, zero fill; MISO = new MSB.
REQ-025 On CS rising edge with bit counter == WORD_WIDTH: rx_data <= rx shifter, rx_valid pulses one clk, frame_err stays low.
REQ-026 On CS rising edge with bit counter != WORD_WIDTH (including 0 and overflow): rx_data unchanged, frame_err pulses one clk.
REQ-027 SCLK edges while in IDLE SHALL be ignored.
REQ-028 MISO SHALL be 0 whenever state is IDLE.
REQ-029 Latency: rx_valid asserts SYNC_STAGES+1 clk after the CS rising edge at the pin.
REQ-030 rx_valid and frame_err SHALL never be high together.

Reset
REQ-031 On rst: state IDLE, MISO 0, rx_data 0, rx_valid 0, frame_err 0, tx_underrun 0, active 0, holding register 0, pending 0, shifters and counter 0, synchronizer flops at idle levels (SCLK 0, CS 1, MOSI 0).
REQ-032 rst asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release, a CS still low SHALL NOT start a frame until CS goes high then low.

Verification
REQ-033 tx_load with 0xA5A5_0F0F, then 32-bit frame at SCLK = clk/8 with MOSI 0x8123_4567 -> MISO stream 0xA5A5_0F0F, rx_data 0x8123_4567, one rx_valid pulse, no errors.
REQ-034 Frame with no prior tx_load -> MISO all zeros, one tx_underrun at frame start, rx_valid still at frame end.
REQ-035 CS low, 31 SCLK pulses, CS high -> frame_err pulse, rx_data retains previous 0x8123_4567; repeat with 33 pulses -> frame_err.
REQ-036 tx_load 0x1111_1111 in same clk as CS falling edge (at sync output) -> MISO stream 0x1111_1111, no tx_underrun.
REQ-037 tx_load 0xDEAD_BEEF mid-frame during word 0x0000_FFFF -> current MISO stays 0x0000_FFFF; next frame sends 0xDEAD_BEEF.
REQ-038 rst asserted after bit 12 with CS low -> outputs at reset values immediately, no pulses; subsequent full frame after CS toggle -> correct rx_valid.
